// File: rtl/id_pkg.sv
// id_pkg: opcodes, ALU encoding, control bundle and source-match helper for the ID stage
package id_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI = 6'h0D;
  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;
  typedef struct packed {
    logic reg_wr;
    logic mem_rd;
    logic mem_wr;
    logic alu_src;
    logic branch;
    alu_op_e alu_op;
  } ctrl_t;
  localparam ctrl_t BUBBLE = '{reg_wr: 1'b0, mem_rd: 1'b0, mem_wr: 1'b0, alu_src: 1'b0, branch: 1'b0, alu_op: ALU_ADD};
  function automatic logic src_hit(input logic wr, input logic [4:0] rw, input logic [4:0] ra, input logic [4:0] rb,
                                   input logic use_a, input logic use_b);
    return wr && rw != 5'd0 && ((use_a && rw == ra) || (use_b && rw == rb));
  endfunction
endpackage

// File: rtl/id_operand_fwd.sv
// id_operand_fwd: register-0 force, then EX/MEM, MEM/WB and register-file priority operand select
module id_operand_fwd #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] ra,
  input  logic [DATA_W-1:0] bus,
  input  logic              exmem_wr,
  input  logic [REG_AW-1:0] exmem_rw,
  input  logic [DATA_W-1:0] exmem_res,
  input  logic              memwb_wr,
  input  logic [REG_AW-1:0] memwb_rw,
  input  logic [DATA_W-1:0] memwb_di,
  output logic [DATA_W-1:0] opnd
);
  always_comb opnd = ra == '0 ? '0 :
                     (exmem_wr && exmem_rw == ra) ? exmem_res :
                     (memwb_wr && memwb_rw == ra) ? memwb_di : bus;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode, forwarding, hazard stall and ID/EX pipeline register
module id_ex_stage import id_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              IfId_Valid,
  input  logic [31:0]       IfId_Instr,
  input  logic [DATA_W-1:0] IfId_PC4,
  output logic [REG_AW-1:0] Ra,
  output logic [REG_AW-1:0] Rb,
  input  logic [DATA_W-1:0] busA,
  input  logic [DATA_W-1:0] busB,
  input  logic              ExMem_RegWr,
  input  logic              ExMem_MemRd,
  input  logic [REG_AW-1:0] ExMem_Rw,
  input  logic [DATA_W-1:0] ExMem_Result,
  input  logic              MemWb_RegWr,
  input  logic [REG_AW-1:0] MemWb_Rw,
  input  logic [DATA_W-1:0] MemWb_Di,
  input  logic              Flush,
  output logic              Stall,
  output logic              IdEx_Valid,
  output logic              IdEx_RegWr,
  output logic              IdEx_MemRd,
  output logic              IdEx_MemWr,
  output logic              IdEx_ALUSrc,
  output logic              IdEx_Branch,
  output logic [2:0]        IdEx_ALUOp,
  output logic [REG_AW-1:0] IdEx_Rw,
  output logic [DATA_W-1:0] IdEx_A,
  output logic [DATA_W-1:0] IdEx_B,
  output logic [DATA_W-1:0] IdEx_Imm,
  output logic [DATA_W-1:0] IdEx_PC4,
  output logic [15:0]       BubbleCnt
);
  logic [5:0] op, fn;
  logic [REG_AW-1:0] rd, rw;
  logic r_ok, dec_ok, use_rt, kill;
  logic [DATA_W-1:0] imm, opnd_a, opnd_b;
  ctrl_t ctl, ctl_q;
  assign op = IfId_Instr[31:26];
  assign fn = IfId_Instr[5:0];
  assign Ra = IfId_Instr[25:21];
  assign Rb = IfId_Instr[20:16];
  assign rd = IfId_Instr[15:11];
  assign r_ok = fn == FN_ADD || fn == FN_SUB || fn == FN_AND || fn == FN_OR || fn == FN_SLT;
  always_comb begin
    ctl = BUBBLE;
    rw = '0;
    use_rt = 1'b0;
    dec_ok = 1'b1;
    imm = {{(DATA_W-16){IfId_Instr[15]}}, IfId_Instr[15:0]};
    case (op)
      OP_RTYPE: begin
        dec_ok = r_ok;
        use_rt = r_ok;
        ctl.reg_wr = r_ok;
        ctl.alu_op = fn == FN_SUB ? ALU_SUB : fn == FN_AND ? ALU_AND : fn == FN_OR ? ALU_OR :
                     fn == FN_SLT ? ALU_SLT : ALU_ADD;
        rw = r_ok ? rd : '0;
      end
      OP_ADDI: begin
        ctl.reg_wr = 1'b1;
        ctl.alu_src = 1'b1;
        rw = Rb;
      end
      OP_ORI: begin
        ctl.reg_wr = 1'b1;
        ctl.alu_src = 1'b1;
        ctl.alu_op = ALU_OR;
        rw = Rb;
        imm = {{(DATA_W-16){1'b0}}, IfId_Instr[15:0]};
      end
      OP_LW: begin
        ctl.reg_wr = 1'b1;
        ctl.mem_rd = 1'b1;
        ctl.alu_src = 1'b1;
        rw = Rb;
      end
      OP_SW: begin
        ctl.mem_wr = 1'b1;
        ctl.alu_src = 1'b1;
        use_rt = 1'b1;
      end
      OP_BEQ: begin
        ctl.branch = 1'b1;
        ctl.alu_op = ALU_SUB;
        use_rt = 1'b1;
      end
      default: dec_ok = 1'b0;
    endcase
  end
  id_operand_fwd #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_a (
    .ra(Ra), .bus(busA), .exmem_wr(ExMem_RegWr), .exmem_rw(ExMem_Rw), .exmem_res(ExMem_Result),
    .memwb_wr(MemWb_RegWr), .memwb_rw(MemWb_Rw), .memwb_di(MemWb_Di), .opnd(opnd_a)
  );
  id_operand_fwd #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_b (
    .ra(Rb), .bus(busB), .exmem_wr(ExMem_RegWr), .exmem_rw(ExMem_Rw), .exmem_res(ExMem_Result),
    .memwb_wr(MemWb_RegWr), .memwb_rw(MemWb_Rw), .memwb_di(MemWb_Di), .opnd(opnd_b)
  );
  assign Stall = IfId_Valid && !Flush && !Reset &&
                 (src_hit(IdEx_Valid && IdEx_RegWr, IdEx_Rw, Ra, Rb, dec_ok, use_rt) ||
                  src_hit(ExMem_MemRd && ExMem_RegWr, ExMem_Rw, Ra, Rb, dec_ok, use_rt));
  assign kill = Flush || Stall;
  always_ff @(posedge CLK) begin
    if (Reset) begin
      IdEx_Valid <= 1'b0;
      ctl_q <= BUBBLE;
      IdEx_Rw <= '0;
      IdEx_A <= '0;
      IdEx_B <= '0;
      IdEx_Imm <= '0;
      IdEx_PC4 <= '0;
      BubbleCnt <= '0;
    end else begin
      IdEx_Valid <= IfId_Valid && !kill;
      ctl_q <= kill ? BUBBLE : ctl;
      IdEx_Rw <= kill ? '0 : rw;
      IdEx_A <= kill ? '0 : opnd_a;
      IdEx_B <= kill ? '0 : opnd_b;
      IdEx_Imm <= kill ? '0 : imm;
      IdEx_PC4 <= kill ? '0 : IfId_PC4;
      if (Stall && BubbleCnt != 16'hFFFF) BubbleCnt <= BubbleCnt + 16'd1;
    end
  end
  assign {IdEx_RegWr, IdEx_MemRd, IdEx_MemWr, IdEx_ALUSrc, IdEx_Branch, IdEx_ALUOp} = ctl_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: vector table plus scoreboarded hazard, flush, saturation and reset sequences
module tb_id_ex_stage;
  typedef struct packed {
    logic v, rwe, mrd, mwr, asrc, br;
    logic [2:0] op;
    logic [4:0] rw;
    logic [31:0] a, b, imm, pc4;
  } exp_t;
  typedef struct {
    logic iv;
    logic [31:0] ins, ba, bb;
    logic ew;
    logic [4:0] erw;
    logic [31:0] eres;
    logic mw;
    logic [4:0] mrw;
    logic [31:0] mdi;
    exp_t e;
  } vec_t;
  logic CLK, Reset, IfId_Valid, Flush, Stall;
  logic [31:0] IfId_Instr, IfId_PC4, busA, busB, ExMem_Result, MemWb_Di;
  logic [4:0] Ra, Rb, ExMem_Rw, MemWb_Rw, IdEx_Rw;
  logic ExMem_RegWr, ExMem_MemRd, MemWb_RegWr;
  logic IdEx_Valid, IdEx_RegWr, IdEx_MemRd, IdEx_MemWr, IdEx_ALUSrc, IdEx_Branch;
  logic [2:0] IdEx_ALUOp;
  logic [31:0] IdEx_A, IdEx_B, IdEx_Imm, IdEx_PC4;
  logic [15:0] BubbleCnt;
  int n_cmp = 0, n_bad = 0;
  exp_t sb[$];
  vec_t vq[$];
  id_ex_stage dut (
    .CLK(CLK), .Reset(Reset), .IfId_Valid(IfId_Valid), .IfId_Instr(IfId_Instr), .IfId_PC4(IfId_PC4),
    .Ra(Ra), .Rb(Rb), .busA(busA), .busB(busB),
    .ExMem_RegWr(ExMem_RegWr), .ExMem_MemRd(ExMem_MemRd), .ExMem_Rw(ExMem_Rw), .ExMem_Result(ExMem_Result),
    .MemWb_RegWr(MemWb_RegWr), .MemWb_Rw(MemWb_Rw), .MemWb_Di(MemWb_Di), .Flush(Flush), .Stall(Stall),
    .IdEx_Valid(IdEx_Valid), .IdEx_RegWr(IdEx_RegWr), .IdEx_MemRd(IdEx_MemRd), .IdEx_MemWr(IdEx_MemWr),
    .IdEx_ALUSrc(IdEx_ALUSrc), .IdEx_Branch(IdEx_Branch), .IdEx_ALUOp(IdEx_ALUOp), .IdEx_Rw(IdEx_Rw),
    .IdEx_A(IdEx_A), .IdEx_B(IdEx_B), .IdEx_Imm(IdEx_Imm), .IdEx_PC4(IdEx_PC4), .BubbleCnt(BubbleCnt)
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  function automatic logic [31:0] r_i(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction
  function automatic logic [31:0] i_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] im);
    return {op, rs, rt, im};
  endfunction
  function automatic logic [31:0] sx(logic [31:0] ins);
    return {{16{ins[15]}}, ins[15:0]};
  endfunction
  function automatic exp_t ex(logic v, logic rwe, logic mrd, logic mwr, logic asrc, logic br, logic [2:0] op,
                              logic [4:0] rw, logic [31:0] a, logic [31:0] b, logic [31:0] imm, logic [31:0] pc4);
    return '{v: v, rwe: rwe, mrd: mrd, mwr: mwr, asrc: asrc, br: br, op: op, rw: rw, a: a, b: b, imm: imm, pc4: pc4};
  endfunction
  function automatic exp_t got();
    return exp_t'({IdEx_Valid, IdEx_RegWr, IdEx_MemRd, IdEx_MemWr, IdEx_ALUSrc, IdEx_Branch, IdEx_ALUOp,
                   IdEx_Rw, IdEx_A, IdEx_B, IdEx_Imm, IdEx_PC4});
  endfunction
  task automatic chk(string nm, logic [159:0] act, logic [159:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: actual %h expected %h", nm, act, want);
    end
  endtask
  task automatic pop_cmp(string nm);
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: scoreboard empty", nm);
    end else chk(nm, got(), sb.pop_front());
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic drv(logic iv, logic [31:0] ins, logic [31:0] ba, logic [31:0] bb, logic ew, logic emr,
                     logic [4:0] erw, logic [31:0] eres, logic mw, logic [4:0] mrw, logic [31:0] mdi);
    IfId_Valid = iv;
    IfId_Instr = ins;
    busA = ba;
    busB = bb;
    ExMem_RegWr = ew;
    ExMem_MemRd = emr;
    ExMem_Rw = erw;
    ExMem_Result = eres;
    MemWb_RegWr = mw;
    MemWb_Rw = mrw;
    MemWb_Di = mdi;
  endtask
  task automatic add_vec(logic iv, logic [31:0] ins, logic [31:0] ba, logic [31:0] bb, logic ew, logic [4:0] erw,
                         logic [31:0] eres, logic mw, logic [4:0] mrw, logic [31:0] mdi, exp_t e);
    vq.push_back('{iv: iv, ins: ins, ba: ba, bb: bb, ew: ew, erw: erw, eres: eres, mw: mw, mrw: mrw, mdi: mdi, e: e});
  endtask
  initial begin
    logic [31:0] w;
    exp_t e;
    Reset = 1'b1;
    Flush = 1'b0;
    IfId_PC4 = 32'h40;
    w = r_i(5'd1, 5'd2, 5'd3, 6'h20);
    drv(1'b1, w, 32'h1, 32'h2, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    for (int k = 0; k < 2; k++) begin
      sb.push_back('0);
      tick();
      pop_cmp("reset_outputs");
      chk("reset_stall", 160'(Stall), 160'(1'b0));
      chk("reset_bubblecnt", 160'(BubbleCnt), 160'(16'd0));
    end
    Reset = 1'b0;
    #1;
    chk("release_stall", 160'(Stall), 160'(1'b0));
    sb.push_back(ex(1, 1, 0, 0, 0, 0, 3'd0, 5'd3, 32'h1, 32'h2, sx(w), 32'h40));
    tick();
    pop_cmp("release_add");
    w = r_i(5'd1, 5'd2, 5'd3, 6'h20);
    add_vec(1, w, 32'hA1, 32'hB0B0, 1, 5'd1, 32'h11, 1, 5'd1, 32'h22, ex(1, 1, 0, 0, 0, 0, 3'd0, 5'd3, 32'h11, 32'hB0B0, sx(w), 0));
    w = r_i(5'd2, 5'd4, 5'd7, 6'h22);
    add_vec(1, w, 32'hAAAA, 32'h44, 0, 5'd0, 32'h0, 1, 5'd2, 32'h33, ex(1, 1, 0, 0, 0, 0, 3'd1, 5'd7, 32'h33, 32'h44, sx(w), 0));
    w = r_i(5'd5, 5'd6, 5'd8, 6'h24);
    add_vec(1, w, 32'h5050, 32'h6060, 1, 5'd9, 32'h99, 1, 5'd10, 32'h1010, ex(1, 1, 0, 0, 0, 0, 3'd2, 5'd8, 32'h5050, 32'h6060, sx(w), 0));
    w = r_i(5'd1, 5'd0, 5'd10, 6'h25);
    add_vec(1, w, 32'h1111, 32'hDEAD, 1, 5'd0, 32'h77, 0, 5'd0, 32'h0, ex(1, 1, 0, 0, 0, 0, 3'd3, 5'd10, 32'h1111, 32'h0, sx(w), 0));
    w = r_i(5'd12, 5'd13, 5'd11, 6'h2A);
    add_vec(1, w, 32'h1, 32'h2, 1, 5'd13, 32'h5, 1, 5'd12, 32'hFFFFFFF0, ex(1, 1, 0, 0, 0, 0, 3'd4, 5'd11, 32'hFFFFFFF0, 32'h5, sx(w), 0));
    w = i_i(6'h08, 5'd0, 5'd4, 16'hFFFF);
    add_vec(1, w, 32'hDEAD, 32'h4444, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, ex(1, 1, 0, 0, 1, 0, 3'd0, 5'd4, 32'h0, 32'h4444, 32'hFFFFFFFF, 0));
    w = i_i(6'h0D, 5'd1, 5'd14, 16'h8000);
    add_vec(1, w, 32'h0F0F, 32'h1400, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, ex(1, 1, 0, 0, 1, 0, 3'd3, 5'd14, 32'h0F0F, 32'h1400, 32'h00008000, 0));
    w = i_i(6'h23, 5'd1, 5'd15, 16'h0010);
    add_vec(1, w, 32'h2000, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, ex(1, 1, 1, 0, 1, 0, 3'd0, 5'd15, 32'h2000, 32'h0, 32'h10, 0));
    w = i_i(6'h2B, 5'd2, 5'd16, 16'hFFFC);
    add_vec(1, w, 32'h3000, 32'hCAFE, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, ex(1, 0, 0, 1, 1, 0, 3'd0, 5'd0, 32'h3000, 32'hCAFE, 32'hFFFFFFFC, 0));
    w = i_i(6'h04, 5'd1, 5'd2, 16'h0003);
    add_vec(1, w, 32'h7, 32'h7, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, ex(1, 0, 0, 0, 0, 1, 3'd1, 5'd0, 32'h7, 32'h7, 32'h3, 0));
    w = i_i(6'h3F, 5'd1, 5'd2, 16'h1234);
    add_vec(1, w, 32'hA, 32'hB, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, ex(1, 0, 0, 0, 0, 0, 3'd0, 5'd0, 32'hA, 32'hB, 32'h1234, 0));
    w = r_i(5'd1, 5'd2, 5'd9, 6'h27);
    add_vec(1, w, 32'hC, 32'hD, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, ex(1, 0, 0, 0, 0, 0, 3'd0, 5'd0, 32'hC, 32'hD, sx(w), 0));
    w = i_i(6'h3F, 5'd3, 5'd4, 16'h8001);
    add_vec(0, w, 32'hE, 32'hF, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, ex(0, 0, 0, 0, 0, 0, 3'd0, 5'd0, 32'hE, 32'hF, 32'hFFFF8001, 0));
    foreach (vq[i]) begin
      drv(vq[i].iv, vq[i].ins, vq[i].ba, vq[i].bb, vq[i].ew, 1'b0, vq[i].erw, vq[i].eres, vq[i].mw, vq[i].mrw, vq[i].mdi);
      IfId_PC4 = 32'h1000 + 32'(4 * i);
      #1;
      chk($sformatf("vec%0d_stall", i), 160'(Stall), 160'(1'b0));
      e = vq[i].e;
      e.pc4 = IfId_PC4;
      sb.push_back(e);
      tick();
      pop_cmp($sformatf("vec%0d", i));
    end
    IfId_PC4 = 32'h80;
    w = i_i(6'h23, 5'd1, 5'd5, 16'h0000);
    drv(1, w, 32'h100, 32'h0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    #1;
    chk("lw_stall", 160'(Stall), 160'(1'b0));
    sb.push_back(ex(1, 1, 1, 0, 1, 0, 3'd0, 5'd5, 32'h100, 32'h0, 32'h0, 32'h80));
    tick();
    pop_cmp("lw_load");
    w = r_i(5'd5, 5'd5, 5'd6, 6'h20);
    drv(1, w, 32'hBAD, 32'hBAD, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    #1;
    chk("lu_stall1", 160'(Stall), 160'(1'b1));
    sb.push_back('0);
    tick();
    pop_cmp("lu_bubble1");
    drv(1, w, 32'hBAD, 32'hBAD, 1, 1, 5'd5, 32'h100, 0, 5'd0, 32'h0);
    #1;
    chk("lu_stall2", 160'(Stall), 160'(1'b1));
    sb.push_back('0);
    tick();
    pop_cmp("lu_bubble2");
    drv(1, w, 32'hBAD, 32'hBAD, 0, 0, 5'd0, 32'h0, 1, 5'd5, 32'h5555);
    #1;
    chk("lu_stall3", 160'(Stall), 160'(1'b0));
    sb.push_back(ex(1, 1, 0, 0, 0, 0, 3'd0, 5'd6, 32'h5555, 32'h5555, sx(w), 32'h80));
    tick();
    pop_cmp("lu_add");
    chk("lu_bubblecnt", 160'(BubbleCnt), 160'(16'd2));
    w = r_i(5'd1, 5'd2, 5'd20, 6'h20);
    drv(1, w, 32'h1, 32'h2, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    sb.push_back(ex(1, 1, 0, 0, 0, 0, 3'd0, 5'd20, 32'h1, 32'h2, sx(w), 32'h80));
    tick();
    pop_cmp("alu_prod");
    w = r_i(5'd20, 5'd1, 5'd21, 6'h22);
    drv(1, w, 32'hBAD, 32'h9, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    #1;
    chk("alu_stall", 160'(Stall), 160'(1'b1));
    sb.push_back('0);
    tick();
    pop_cmp("alu_bubble");
    drv(1, w, 32'hBAD, 32'h9, 1, 0, 5'd20, 32'h77, 0, 5'd0, 32'h0);
    #1;
    chk("alu_nostall", 160'(Stall), 160'(1'b0));
    sb.push_back(ex(1, 1, 0, 0, 0, 0, 3'd1, 5'd21, 32'h77, 32'h9, sx(w), 32'h80));
    tick();
    pop_cmp("alu_cons");
    chk("alu_bubblecnt", 160'(BubbleCnt), 160'(16'd3));
    drv(0, r_i(5'd5, 5'd5, 5'd6, 6'h20), 32'h0, 32'h0, 1, 1, 5'd5, 32'h0, 0, 5'd0, 32'h0);
    #1;
    chk("invalid_stall", 160'(Stall), 160'(1'b0));
    tick();
    chk("invalid_valid", 160'(IdEx_Valid), 160'(1'b0));
    chk("invalid_bubblecnt", 160'(BubbleCnt), 160'(16'd3));
    w = r_i(5'd1, 5'd2, 5'd22, 6'h20);
    drv(1, w, 32'h3, 32'h4, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    sb.push_back(ex(1, 1, 0, 0, 0, 0, 3'd0, 5'd22, 32'h3, 32'h4, sx(w), 32'h80));
    tick();
    pop_cmp("flush_prod");
    drv(1, r_i(5'd22, 5'd22, 5'd23, 6'h25), 32'h0, 32'h0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    Flush = 1'b1;
    #1;
    chk("flush_stall", 160'(Stall), 160'(1'b0));
    sb.push_back('0);
    tick();
    pop_cmp("flush_bubble");
    chk("flush_bubblecnt", 160'(BubbleCnt), 160'(16'd3));
    Flush = 1'b0;
    drv(1, r_i(5'd5, 5'd5, 5'd6, 6'h20), 32'h0, 32'h0, 1, 1, 5'd5, 32'h0, 0, 5'd0, 32'h0);
    #1;
    chk("sat_stall", 160'(Stall), 160'(1'b1));
    repeat (65531) tick();
    chk("sat_minus1", 160'(BubbleCnt), 160'(16'hFFFE));
    tick();
    chk("sat_reach", 160'(BubbleCnt), 160'(16'hFFFF));
    repeat (8) tick();
    chk("sat_hold", 160'(BubbleCnt), 160'(16'hFFFF));
    chk("sat_valid", 160'(IdEx_Valid), 160'(1'b0));
    w = r_i(5'd1, 5'd2, 5'd24, 6'h20);
    drv(1, w, 32'h5, 32'h6, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    sb.push_back(ex(1, 1, 0, 0, 0, 0, 3'd0, 5'd24, 32'h5, 32'h6, sx(w), 32'h80));
    tick();
    pop_cmp("mid_prod");
    drv(1, r_i(5'd24, 5'd24, 5'd25, 6'h20), 32'h0, 32'h0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    Reset = 1'b1;
    #1;
    chk("mid_reset_stall", 160'(Stall), 160'(1'b0));
    sb.push_back('0);
    tick();
    pop_cmp("mid_reset_out");
    chk("mid_reset_bubblecnt", 160'(BubbleCnt), 160'(16'd0));
    chk("mid_reset_stall_held", 160'(Stall), 160'(1'b0));
    Reset = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
